// File: rtl/vec_issue_ctrl.sv
// Issue sequencer for the shared vector unit: issues one vector op, meters scalar
// dispatch behind it, freezes fetch, and runs the release sequence. Optional watchdog: VEC_TIMEOUT_EN.
module vec_issue_ctrl #(
  parameter int LIM_SV     = 5,
  parameter int LIM_VV     = 6,
  parameter int REL_CYCLES = 2
`ifdef VEC_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 1024
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       vec_inst_valid,
  input  logic       sv_vv,
  input  logic       scalar_dispatch,
  input  logic       vec_unit_done,
  input  logic       IF_ID_Freeze,
  input  logic       Branch_Taken__EX_MEM,
  input  logic       PC_Control__IRQ,
  output logic       vec_issue,
  output logic       Vector__Stall,
  output logic       Vector__freeze,
  output logic [1:0] Vector_release_counter,
  output logic [2:0] disp_cnt
`ifdef VEC_TIMEOUT_EN
  ,
  output logic       vec_timeout_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FROZEN, S_RELEASE} state_t;

  state_t     state;
  logic [2:0] lim;
  logic       hazard;
  logic       accept;
  logic       done_evt;
  logic [3:0] disp_sum;
  logic [2:0] disp_sat;

  assign accept = (state == S_IDLE) & vec_inst_valid & ~IF_ID_Freeze &
                  ~Branch_Taken__EX_MEM & ~PC_Control__IRQ;

  // Count including this cycle's dispatch, saturated at the latched limit.
  assign disp_sum = {1'b0, disp_cnt} + {3'b000, scalar_dispatch};
  assign disp_sat = (disp_sum > {1'b0, lim}) ? lim : disp_sum[2:0];

`ifdef VEC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  assign wd_hit   = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign done_evt = vec_unit_done | wd_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt          <= '0;
      vec_timeout_err <= 1'b0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == S_BUSY || state == S_FROZEN) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_hit) vec_timeout_err <= 1'b1;
    end
  end
`else
  assign done_evt = vec_unit_done;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                  <= S_IDLE;
      lim                    <= '0;
      hazard                 <= 1'b0;
      disp_cnt               <= '0;
      vec_issue              <= 1'b0;
      Vector__Stall          <= 1'b0;
      Vector__freeze         <= 1'b0;
      Vector_release_counter <= '0;
    end else begin
      // NOTE: strobe defaults low here so it is high for exactly the first BUSY cycle.
      vec_issue <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_BUSY;
            disp_cnt      <= '0;
            lim           <= sv_vv ? 3'(LIM_SV) : 3'(LIM_VV);
            hazard        <= 1'b0;
            vec_issue     <= 1'b1;
            Vector__Stall <= 1'b1;
          end
        end
        S_BUSY: begin
          disp_cnt <= disp_sat;
          if (done_evt) begin
            state                  <= S_RELEASE;
            Vector_release_counter <= 2'd1;
            Vector__freeze         <= hazard;
          end else if (vec_inst_valid) begin
            state          <= S_FROZEN;
            hazard         <= 1'b1;
            Vector__freeze <= 1'b1;
          end else if (disp_sum == {1'b0, lim}) begin
            state          <= S_FROZEN;
            Vector__freeze <= 1'b1;
          end
        end
        S_FROZEN: begin
          if (done_evt) begin
            state                  <= S_RELEASE;
            Vector_release_counter <= 2'd1;
            Vector__freeze         <= hazard;
          end
        end
        S_RELEASE: begin
          if (Vector_release_counter == 2'(REL_CYCLES)) begin
            state                  <= S_IDLE;
            hazard                 <= 1'b0;
            disp_cnt               <= '0;
            Vector__Stall          <= 1'b0;
            Vector__freeze         <= 1'b0;
            Vector_release_counter <= '0;
          end else begin
            Vector_release_counter <= Vector_release_counter + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed plus random bench for vec_issue_ctrl against a cycle-level reference model.
module tb_vec_issue_ctrl;

  localparam int LIM_SV     = 5;
  localparam int LIM_VV     = 6;
  localparam int REL_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       vec_inst_valid = 1'b0;
  logic       sv_vv = 1'b0;
  logic       scalar_dispatch = 1'b0;
  logic       vec_unit_done = 1'b0;
  logic       IF_ID_Freeze = 1'b0;
  logic       Branch_Taken__EX_MEM = 1'b0;
  logic       PC_Control__IRQ = 1'b0;
  logic       vec_issue;
  logic       Vector__Stall;
  logic       Vector__freeze;
  logic [1:0] Vector_release_counter;
  logic [2:0] disp_cnt;
  logic       vec_timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: op in flight, frozen flag, release step, counters.
  bit m_first, m_active, m_frz, m_haz, m_err;
  int m_rel, m_cnt, m_lim, m_age;

  vec_issue_ctrl #(
    .LIM_SV(LIM_SV), .LIM_VV(LIM_VV), .REL_CYCLES(REL_CYCLES)
`ifdef VEC_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .vec_inst_valid(vec_inst_valid), .sv_vv(sv_vv),
    .scalar_dispatch(scalar_dispatch), .vec_unit_done(vec_unit_done),
    .IF_ID_Freeze(IF_ID_Freeze), .Branch_Taken__EX_MEM(Branch_Taken__EX_MEM),
    .PC_Control__IRQ(PC_Control__IRQ),
    .vec_issue(vec_issue), .Vector__Stall(Vector__Stall),
    .Vector__freeze(Vector__freeze), .Vector_release_counter(Vector_release_counter),
    .disp_cnt(disp_cnt)
`ifdef VEC_TIMEOUT_EN
    , .vec_timeout_err(vec_timeout_err)
`endif
  );

`ifndef VEC_TIMEOUT_EN
  assign vec_timeout_err = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  sum;
    bit  fin;
    bit  acc;
    acc = 1'b0;
    if (RST) begin
      m_first = 0; m_active = 0; m_frz = 0; m_haz = 0; m_err = 0;
      m_rel = 0; m_cnt = 0; m_lim = 0; m_age = 0;
      return;
    end
    if (m_rel != 0) begin
      if (m_rel == REL_CYCLES) begin
        m_rel = 0; m_haz = 0; m_cnt = 0;
      end else begin
        m_rel++;
      end
    end else if (m_active) begin
      m_age++;
      fin = vec_unit_done;
`ifdef VEC_TIMEOUT_EN
      if (m_age >= TIMEOUT) begin
        fin = 1; m_err = 1;
      end
`endif
      if (!m_frz) begin
        sum   = m_cnt + int'(scalar_dispatch);
        m_cnt = (sum > m_lim) ? m_lim : sum;
        if (!fin && vec_inst_valid) begin
          m_frz = 1; m_haz = 1;
        end else if (!fin && sum == m_lim) begin
          m_frz = 1;
        end
      end
      if (fin) begin
        m_active = 0; m_frz = 0; m_rel = 1;
      end
    end else if (vec_inst_valid && !IF_ID_Freeze && !Branch_Taken__EX_MEM && !PC_Control__IRQ) begin
      acc = 1; m_active = 1; m_cnt = 0; m_haz = 0; m_age = 0;
      m_lim = sv_vv ? LIM_SV : LIM_VV;
    end
    m_first = acc;
  endtask

  task automatic check_all();
    check("vec_issue", int'(vec_issue), int'(m_first));
    check("stall", int'(Vector__Stall), int'(m_active || m_rel != 0));
    check("freeze", int'(Vector__freeze), int'(m_frz || (m_rel != 0 && m_haz)));
    check("rel_cnt", int'(Vector_release_counter), m_rel);
    check("disp_cnt", int'(disp_cnt), m_cnt);
`ifdef VEC_TIMEOUT_EN
    check("timeout_err", int'(vec_timeout_err), int'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_in(input bit v, input bit sv, input bit sd, input bit dn);
    vec_inst_valid = v; sv_vv = sv; scalar_dispatch = sd; vec_unit_done = dn;
  endtask

  initial begin
    // Reset held with a vector instruction present.
    RST = 1'b1;
    set_in(1, 0, 0, 0);
    tick();
    tick();
    check("rst_issue", int'(vec_issue), 0);
    check("rst_stall", int'(Vector__Stall), 0);

    // Vector-vector op: freeze after sixth dispatch.
    RST = 1'b0;
    set_in(1, 0, 0, 0);
    tick();
    check("vv_issue", int'(vec_issue), 1);
    set_in(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    check("vv_freeze", int'(Vector__freeze), 1);
    check("vv_cnt", int'(disp_cnt), 6);
    set_in(0, 0, 0, 1);
    tick();
    check("vv_rel1", int'(Vector_release_counter), 1);
    set_in(0, 0, 0, 0);
    tick();
    check("vv_rel2", int'(Vector_release_counter), 2);
    tick();
    check("vv_idle", int'(Vector__Stall), 0);

    // Scalar-vector op completing early.
    set_in(1, 1, 0, 0);
    tick();
    set_in(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    set_in(0, 1, 0, 1);
    tick();
    check("sv_rel_cnt", int'(disp_cnt), 3);
    check("sv_nofreeze", int'(Vector__freeze), 0);
    set_in(0, 1, 0, 0);
    tick();
    tick();

    // Structural hazard: second vector instruction held until IDLE.
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0);
    tick();
    check("hz_freeze", int'(Vector__freeze), 1);
    set_in(1, 0, 0, 1);
    tick();
    check("hz_rel_freeze", int'(Vector__freeze), 1);
    set_in(1, 0, 0, 0);
    tick();
    tick();
    check("hz_idle_noissue", int'(vec_issue), 0);
    tick();
    check("hz_reissue", int'(vec_issue), 1);
    set_in(0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    tick();

    // Blocked accept by branch, interrupt and pipeline freeze.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 0);
      Branch_Taken__EX_MEM = (k == 0);
      PC_Control__IRQ      = (k == 1);
      IF_ID_Freeze         = (k == 2);
      tick();
      check("blk_noissue", int'(vec_issue), 0);
      Branch_Taken__EX_MEM = 0; PC_Control__IRQ = 0; IF_ID_Freeze = 0;
      tick();
      check("blk_issue", int'(vec_issue), 1);
      set_in(0, 1, 0, 1);
      tick();
      set_in(0, 1, 0, 0);
      tick();
      tick();
    end

    // Done while idle is ignored.
    set_in(0, 0, 0, 1);
    tick();
    check("idle_done", int'(Vector_release_counter), 0);

    // Done and limit-reaching dispatch together: done wins.
    set_in(1, 1, 0, 0);
    tick();
    set_in(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    set_in(0, 1, 1, 1);
    tick();
    check("race_rel", int'(Vector_release_counter), 1);
    check("race_nofreeze", int'(Vector__freeze), 0);
    set_in(0, 1, 0, 0);
    tick();
    tick();

    // Reset mid-operation abandons the op.
    set_in(1, 0, 1, 0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("midrst_stall", int'(Vector__Stall), 0);
    RST = 1'b0;
    set_in(0, 0, 0, 0);
    tick();

`ifdef VEC_TIMEOUT_EN
    // Watchdog: no done for TIMEOUT cycles.
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) tick();
    check("wd_err", int'(vec_timeout_err), 1);
    check("wd_rel", int'(Vector_release_counter), 1);
    tick();
    tick();
    check("wd_sticky", int'(vec_timeout_err), 1);
    check("wd_idle", int'(Vector__Stall), 0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      RST                  = ($urandom_range(0, 79) == 0);
      vec_inst_valid       = ($urandom_range(0, 5) == 0);
      sv_vv                = $urandom_range(0, 1) == 1;
      scalar_dispatch      = $urandom_range(0, 1) == 1;
      vec_unit_done        = ($urandom_range(0, 9) == 0);
      IF_ID_Freeze         = ($urandom_range(0, 7) == 0);
      Branch_Taken__EX_MEM = ($urandom_range(0, 7) == 0);
      PC_Control__IRQ      = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
